board_engine: RTL and testbench

BOARD_ENGINE -- requirements
Module: board_engine

---
 rtl/board_engine.sv | 168 ++++++++++++++++
 tb/tb_board_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_engine.sv
// board_engine: flood-fill board engine with clear, random init, move, end-of-game check and plotter read port
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   sig_reset / donereset       clear board request and completion pulse
//   initupdate / doneinitiupdate  random board request and completion pulse
//   update, colorin / doneupdate  flood move request with move colour, completion pulse
//   check / doneCheck, gameOver   end-of-game evaluation request, completion pulse, result
//   steps                       moves taken (saturates at 63)
//   rd_addr / rd_color          plotter cell index and its registered colour (one cycle latency)
// Build option: define BOARD_STEP_LIMIT_EN to also end the game once steps reaches MAX_STEPS.
module board_engine #(
   parameter int GRID_N    = 8,
   parameter int MAX_STEPS = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sig_reset,
   output logic       donereset,
   input  logic       initupdate,
   output logic       doneinitiupdate,
   input  logic       update,
   input  logic [2:0] colorin,
   output logic       doneupdate,
   input  logic       check,
   output logic       doneCheck,
   output logic       gameOver,
   output logic [5:0] steps,
   input  logic [5:0] rd_addr,
   output logic [2:0] rd_color
);
   localparam int N  = GRID_N * GRID_N;
   localparam int AW = $clog2(N);
`ifdef BOARD_STEP_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, CLEAR, INIT_FILL, RECOLOR, GROW, DONE, WAIT_LOW} state_t;
   typedef enum logic [1:0] {K_RESET, K_INIT, K_UPDATE, K_CHECK} kind_t;

   function automatic logic [N-1:0] col_mask(input int k);
      col_mask = '0;
      for (int i = 0; i < N; i++) col_mask[i] = (i % GRID_N == k);
   endfunction

   // Horizontal shifts of the owned mask must not carry across row ends.
   localparam logic [N-1:0] FIRST_COL = col_mask(0);
   localparam logic [N-1:0] LAST_COL  = col_mask(GRID_N - 1);

   state_t        state;
   kind_t         kind;
   logic [2:0]    board [N];
   logic [N-1:0]  owned, nbr;
   logic [AW-1:0] idx;
   logic          added;
   logic [15:0]   lfsr;
   logic [2:0]    fill_color;
   logic          valid_move, grow_cell, any_req, at_limit, last_cell;

   always_comb begin
      // Bit c of nbr is set when any orthogonal neighbour of cell c is owned.
      nbr = (owned << GRID_N) | (owned >> GRID_N) |
            ((owned << 1) & ~FIRST_COL) | ((owned >> 1) & ~LAST_COL);
      // LFSR bits {b1,b0} map 00->001, 01->101, 10->011, 11->111.
      fill_color = {lfsr[0], lfsr[1], 1'b1};
      // Every valid colour has bit 0 set; empty and the even codes are rejected.
      valid_move = colorin[0] && colorin != board[0];
      grow_cell  = !owned[idx] && board[idx] == board[0] && nbr[idx];
      any_req    = sig_reset | initupdate | update | check;
      at_limit   = LIMIT_EN && (32'(steps) >= MAX_STEPS);
      last_cell  = idx == AW'(N - 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         kind            <= K_RESET;
         idx             <= '0;
         added           <= 1'b0;
         lfsr            <= 16'hACE1;
         owned           <= '0;
         steps           <= '0;
         gameOver        <= 1'b0;
         rd_color        <= '0;
         donereset       <= 1'b0;
         doneinitiupdate <= 1'b0;
         doneupdate      <= 1'b0;
         doneCheck       <= 1'b0;
         for (int i = 0; i < N; i++) board[i] <= '0;
      end else begin
         // Fibonacci form of x^16+x^14+x^13+x^11+1; a non-zero seed never reaches zero.
         lfsr            <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         rd_color        <= (32'(rd_addr) < N) ? board[rd_addr[AW-1:0]] : 3'b000;
         donereset       <= 1'b0;
         doneinitiupdate <= 1'b0;
         doneupdate      <= 1'b0;
         doneCheck       <= 1'b0;
         case (state)
            IDLE: begin
               if (sig_reset) begin
                  kind  <= K_RESET;
                  state <= CLEAR;
               end else if (initupdate) begin
                  kind  <= K_INIT;
                  idx   <= '0;
                  state <= INIT_FILL;
               end else if (update) begin
                  kind  <= K_UPDATE;
                  state <= RECOLOR;
               end else if (check) begin
                  kind     <= K_CHECK;
                  gameOver <= &owned || at_limit;
                  state    <= DONE;
               end
            end
            CLEAR: begin
               for (int i = 0; i < N; i++) board[i] <= '0;
               owned    <= '0;
               steps    <= '0;
               gameOver <= 1'b0;
               state    <= DONE;
            end
            INIT_FILL: begin
               board[idx] <= fill_color;
               idx        <= idx + 1'b1;
               if (last_cell) begin
                  owned    <= N'(1);
                  steps    <= '0;
                  gameOver <= 1'b0;
                  idx      <= '0;
                  added    <= 1'b0;
                  state    <= GROW;
               end
            end
            RECOLOR: begin
               state <= DONE;
               if (valid_move) begin
                  for (int i = 0; i < N; i++) if (owned[i]) board[i] <= colorin;
                  steps <= &steps ? steps : steps + 1'b1;
                  idx   <= '0;
                  added <= 1'b0;
                  state <= GROW;
               end
            end
            GROW: begin
               if (grow_cell) owned[idx] <= 1'b1;
               idx   <= idx + 1'b1;
               added <= added | grow_cell;
               // A pass that owned nothing new means the flood region is complete.
               if (last_cell) begin
                  added <= 1'b0;
                  if (!(added || grow_cell)) state <= DONE;
               end
            end
            DONE: begin
               donereset       <= kind == K_RESET;
               doneinitiupdate <= kind == K_INIT;
               doneupdate      <= kind == K_UPDATE;
               doneCheck       <= kind == K_CHECK;
               state           <= WAIT_LOW;
            end
            WAIT_LOW: if (!any_req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: self-checking bench for board_engine (table vectors, corner sequences, random moves vs flood model)
module tb_board_engine;
   localparam int MS = 2;
`ifdef BOARD_STEP_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clk = 1'b0, reset = 1'b1;
   logic       sig_reset = 1'b0, initupdate = 1'b0, update = 1'b0, check = 1'b0;
   logic [2:0] colorin = '0;
   logic [5:0] rd_addr = '0;
   logic       donereset, doneinitiupdate, doneupdate, doneCheck, gameOver;
   logic [5:0] steps;
   logic [2:0] rd_color;

   board_engine #(.GRID_N(8), .MAX_STEPS(MS)) dut (
      .clk(clk), .reset(reset),
      .sig_reset(sig_reset), .donereset(donereset),
      .initupdate(initupdate), .doneinitiupdate(doneinitiupdate),
      .update(update), .colorin(colorin), .doneupdate(doneupdate),
      .check(check), .doneCheck(doneCheck), .gameOver(gameOver),
      .steps(steps), .rd_addr(rd_addr), .rd_color(rd_color)
   );

   always #5 clk = ~clk;

   wire [3:0] dn = {doneCheck, doneupdate, doneinitiupdate, donereset};

   typedef struct {
      int         w;
      logic [2:0] c;
      int         lat;
      int         stp;
      int         go;
   } vec_t;

   int         checks = 0, errors = 0;
   logic [2:0] mb [64];
   bit         mo [64];
   int         msteps;
   logic [2:0] snap [64];
   logic [2:0] first_b [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int w, input logic [2:0] c);
      sig_reset  = (w == 0);
      initupdate = (w == 1);
      update     = (w == 2);
      check      = (w == 3);
      colorin    = c;
   endtask

   task automatic drop;
      set_req(-1, 3'b000);
      tick;
      tick;
   endtask

   task automatic wait_done(input int w, output int lat, output int others);
      lat = 0;
      others = 0;
      for (int i = 0; i < 20000; i++) begin
         tick;
         lat++;
         for (int k = 0; k < 4; k++) if (k != w && dn[k]) others++;
         if (dn[w]) return;
      end
      lat = -1;
   endtask

   task automatic op(input string name, input int w, input logic [2:0] c, output int lat);
      int oth;
      set_req(w, c);
      wait_done(w, lat, oth);
      chk({name, " timeout"}, 32'(lat < 0), 0);
      chk({name, " other done"}, oth, 0);
      tick;
      chk({name, " pulse width"}, dn, 0);
      drop;
   endtask

   task automatic read_board;
      for (int i = 0; i < 64; i++) begin
         rd_addr = 6'(i);
         tick;
         snap[i] = rd_color;
      end
   endtask

   function automatic logic [2:0] cmap(input logic [1:0] b);
      case (b)
         2'd0:    return 3'b001;
         2'd1:    return 3'b101;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   // Either shift direction of the same polynomial is accepted.
   function automatic logic [15:0] lf(input logic [15:0] s, input bit dir);
      return dir ? {s[14:0], ^(s & 16'hB400)} : {^(s & 16'h002D), s[15:1]};
   endfunction

   function automatic bit lfsr_match;
      logic [15:0] s, s2;
      bit ok;
      for (int d = 0; d < 2; d++) begin
         s = 16'hACE1;
         for (int t = 0; t < 500; t++) begin
            s2 = s;
            ok = 1'b1;
            for (int k = 0; k < 64; k++) begin
               if (snap[k] !== cmap(s2[1:0])) ok = 1'b0;
               s2 = lf(s2, d[0]);
            end
            if (ok) return 1'b1;
            s = lf(s, d[0]);
         end
      end
      return 1'b0;
   endfunction

   function automatic int nbr_of(input int c, input int d);
      case (d)
         0:       return c >= 8 ? c - 8 : -1;
         1:       return c < 56 ? c + 8 : -1;
         2:       return c % 8 != 0 ? c - 1 : -1;
         default: return c % 8 != 7 ? c + 1 : -1;
      endcase
   endfunction

   // Flood region = everything reachable from owned cells through cells of cell 0's colour.
   task automatic m_grow;
      int q[$];
      int c, n;
      for (int i = 0; i < 64; i++) if (mo[i]) q.push_back(i);
      while (q.size() > 0) begin
         c = q.pop_front();
         for (int d = 0; d < 4; d++) begin
            n = nbr_of(c, d);
            if (n >= 0 && !mo[n] && mb[n] == mb[0]) begin
               mo[n] = 1'b1;
               q.push_back(n);
            end
         end
      end
   endtask

   function automatic bit m_full;
      for (int i = 0; i < 64; i++) if (!mo[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_valid(input logic [2:0] c);
      return c == 3'b001 || c == 3'b011 || c == 3'b101 || c == 3'b111;
   endfunction

   task automatic m_move(input logic [2:0] c);
      if (!m_valid(c) || c == mb[0]) return;
      for (int i = 0; i < 64; i++) if (mo[i]) mb[i] = c;
      msteps = msteps < 63 ? msteps + 1 : 63;
      m_grow;
   endtask

   task automatic board_vs_model(input string name);
      int bad;
      read_board;
      bad = 0;
      for (int i = 0; i < 64; i++) if (snap[i] !== mb[i]) bad++;
      chk(name, bad, 0);
   endtask

   task automatic move(input string name, input logic [2:0] c);
      int lat;
      bit nop;
      nop = !m_valid(c) || c == mb[0];
      op(name, 2, c, lat);
      m_move(c);
      if (nop) chk({name, " nop latency"}, lat, 3);
      chk({name, " steps"}, steps, msteps);
   endtask

   task automatic game_check(input string name);
      int lat;
      op(name, 3, 3'b000, lat);
      chk({name, " latency"}, lat, 2);
      chk({name, " gameOver"}, gameOver, 32'(m_full() || (LIM && msteps >= MS)));
   endtask

   task automatic fresh_init;
      int lat;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      tick;
      op("init", 1, 3'b000, lat);
   endtask

   initial begin
      vec_t       tbl [6];
      int         lat, oth, bad, cnt;
      logic [2:0] c;

      tbl[0] = '{w: 3, c: 3'b000, lat: 2,  stp: 0, go: 0};
      tbl[1] = '{w: 2, c: 3'b000, lat: 3,  stp: 0, go: -1};
      tbl[2] = '{w: 2, c: 3'b010, lat: 3,  stp: 0, go: -1};
      tbl[3] = '{w: 2, c: 3'b001, lat: 67, stp: 1, go: -1};
      tbl[4] = '{w: 3, c: 3'b000, lat: 2,  stp: 1, go: 0};
      tbl[5] = '{w: 0, c: 3'b000, lat: 3,  stp: 0, go: -1};

      repeat (3) tick;
      chk("reset done outputs", dn, 0);
      chk("reset steps", steps, 0);
      chk("reset gameOver", gameOver, 0);
      chk("reset rd_color", rd_color, 0);
      reset = 1'b0;
      tick;

      op("clear", 0, 3'b000, lat);
      chk("clear latency", lat, 3);
      read_board;
      bad = 0;
      for (int i = 0; i < 64; i++) if (snap[i] !== 3'b000) bad++;
      chk("clear board", bad, 0);
      chk("clear steps", steps, 0);

      for (int i = 0; i < 6; i++) begin
         op($sformatf("vec%0d", i), tbl[i].w, tbl[i].c, lat);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d steps", i), steps, tbl[i].stp);
         if (tbl[i].go >= 0) chk($sformatf("vec%0d gameOver", i), gameOver, tbl[i].go);
      end

      sig_reset = 1'b1;
      initupdate = 1'b1;
      wait_done(0, lat, oth);
      chk("prio reset>init latency", lat, 3);
      chk("prio reset>init other", oth, 0);
      drop;

      update = 1'b1;
      check = 1'b1;
      colorin = 3'b000;
      wait_done(2, lat, oth);
      chk("prio update>check latency", lat, 3);
      chk("prio update>check other", oth, 0);
      cnt = 0;
      repeat (4) begin
         tick;
         if (dn != 0) cnt++;
      end
      chk("prio held no done", cnt, 0);
      drop;
      op("recheck", 3, 3'b000, lat);
      chk("recheck latency", lat, 2);

      set_req(1, 3'b000);
      repeat (10) tick;
      reset = 1'b1;
      set_req(-1, 3'b000);
      cnt = 0;
      repeat (2) begin
         tick;
         if (dn != 0) cnt++;
      end
      reset = 1'b0;
      repeat (150) begin
         tick;
         if (dn != 0) cnt++;
      end
      chk("abort no done", cnt, 0);
      read_board;
      bad = 0;
      for (int i = 0; i < 64; i++) if (snap[i] !== 3'b000) bad++;
      chk("abort board empty", bad, 0);

      fresh_init;
      chk("init steps", steps, 0);
      read_board;
      bad = 0;
      for (int i = 0; i < 64; i++) if (!m_valid(snap[i])) bad++;
      chk("init colours valid", bad, 0);
      chk("init lfsr sequence", 32'(lfsr_match()), 1);
      for (int i = 0; i < 64; i++) first_b[i] = snap[i];
      fresh_init;
      read_board;
      bad = 0;
      for (int i = 0; i < 64; i++) if (snap[i] !== first_b[i]) bad++;
      chk("init repeatable", bad, 0);

      for (int i = 0; i < 64; i++) begin
         mb[i] = first_b[i];
         mo[i] = (i == 0);
      end
      msteps = 0;
      m_grow;
      game_check("init check");

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            7:       c = mb[0];
            8:       c = 3'b000;
            9:       c = 3'(2 * $urandom_range(1, 3));
            default: c = cmap(2'($urandom_range(0, 3)));
         endcase
         if (i < 2) while (c == mb[0] || !m_valid(c)) c = cmap(2'($urandom_range(0, 3)));
         move($sformatf("rnd%0d", i), c);
         if (i % 3 == 1) game_check($sformatf("rnd%0d check", i));
         if (i % 4 == 3 || i == 39) board_vs_model($sformatf("rnd%0d board", i));
      end

      for (int k = 0; k < 200 && !m_full(); k++) begin
         c = 3'b000;
         for (int n = 63; n >= 0; n--)
            if (!mo[n])
               for (int d = 0; d < 4; d++)
                  if (nbr_of(n, d) >= 0 && mo[nbr_of(n, d)]) c = mb[n];
         move($sformatf("flood%0d", k), c);
      end
      board_vs_model("flood board");
      chk("flood full", 32'(m_full()), 1);
      game_check("flood check");

      for (int k = 0; k < 70 && msteps < 63; k++)
         move($sformatf("sat%0d", k), mb[0] == 3'b001 ? 3'b111 : 3'b001);
      move("sat extra", mb[0] == 3'b001 ? 3'b111 : 3'b001);
      chk("steps saturate", steps, 63);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
